// File: rtl/ppa_mp_seq_pkg.sv
// Shared types and constants for the multi-precision add/sub sequencer.
// State encoding, byte width and requester ids live here.
package ppa_mp_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ppa8.sv
// 8-bit Kogge-Stone parallel-prefix adder with carry in/out.
// Three prefix levels (span 1, 2, 4) build group generate/propagate.
module ppa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g0, p0;
    logic [7:0] g1, p1;
    logic [7:0] g2, p2;
    logic [7:0] g3, p3;
    logic [8:0] c;

    // Bit-level generate/propagate and prefix combine per level
    always_comb begin
        g0 = a & b;
        p0 = a ^ b;
        g1 = g0 | (p0 & (g0 << 1));
        p1 = p0 & ~((~p0) << 1);
        g2 = g1 | (p1 & (g1 << 2));
        p2 = p1 & ~((~p1) << 2);
        g3 = g2 | (p2 & (g2 << 4));
        p3 = p2 & ~((~p2) << 4);
        c   = {g3 | (p3 & {8{cin}}), cin};
        sum  = p0 ^ c[7:0];
        cout = c[8];
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last grant.
// Pointer resets to requester 1 so requester 0 wins the first tie.
module rr_arb2
    import ppa_mp_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic update,
    output logic grant0,
    output logic grant1
);

    logic last;

    // Lone requester wins; on a tie the one not granted last wins
    always_comb begin
        grant0 = valid0 & (~valid1 | (last == ID1));
        grant1 = valid1 & (~valid0 | (last == ID0));
    end

    // Record the granted id whenever a grant is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= ID1;
        end else if (update) begin
            last <= grant1 ? ID1 : ID0;
        end
    end

endmodule

// File: rtl/ppa_mp_seq.sv
// Byte-serial multi-precision add/sub over one shared 8-bit adder.
// Two requesters arbitrated round-robin; result on a valid/ready port.
module ppa_mp_seq
    import ppa_mp_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [WORDS*BYTE_W-1:0]   req0_a,
    input  logic [WORDS*BYTE_W-1:0]   req0_b,
    input  logic                      req0_sub,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [WORDS*BYTE_W-1:0]   req1_a,
    input  logic [WORDS*BYTE_W-1:0]   req1_b,
    input  logic                      req1_sub,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WORDS*BYTE_W-1:0]   resp_sum,
    output logic                      resp_cout,
    output logic                      resp_id
);

    localparam int N  = WORDS * BYTE_W;
    localparam int KW = $clog2(WORDS);
    localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

    state_e          state;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic [N-1:0]    sum_r;
    logic            cy;
    logic            id_r;
    logic [KW-1:0]   k;
    logic            g0, g1;
    logic            acc0, acc1;
    logic            idle;
    logic            sel_sub;
    logic [7:0]      byte_a, byte_b, byte_s;
    logic            byte_co;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .update (acc0 | acc1),
        .grant0 (g0),
        .grant1 (g1)
    );

    ppa8 u_ppa8 (
        .a    (byte_a),
        .b    (byte_b),
        .cin  (cy),
        .sum  (byte_s),
        .cout (byte_co)
    );

    // Handshake decode and byte-select mux for the shared adder
    always_comb begin
        idle       = (state == IDLE);
        req0_ready = idle & g0 & ~rst;
        req1_ready = idle & g1 & ~rst;
        acc0       = req0_valid & req0_ready;
        acc1       = req1_valid & req1_ready;
        sel_sub    = acc1 ? req1_sub : req0_sub;
        byte_a     = a_r[k*BYTE_W +: BYTE_W];
        byte_b     = b_r[k*BYTE_W +: BYTE_W];
        resp_valid = (state == DONE);
        resp_cout  = (state == DONE) & cy;
        resp_sum   = sum_r;
        resp_id    = id_r;
    end

    // Accept, byte-serial run with chained carry, then hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            cy    <= 1'b0;
            id_r  <= ID0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 | acc1) begin
                        a_r   <= acc1 ? req1_a : req0_a;
                        b_r   <= (acc1 ? req1_b : req0_b)
                                 ^ {N{sel_sub}};
                        cy    <= sel_sub;
                        id_r  <= acc1 ? ID1 : ID0;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[k*BYTE_W +: BYTE_W] <= byte_s;
                    cy <= byte_co;
                    k  <= k + KW'(1);
                    if (k == KLAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
